// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch responder with a small fully-associative line buffer.
//
// Each decode lane presents fetch_order/fetch_pc; a resident line answers in the same
// cycle through fetch_done/fetch_instr. The lowest missing lane starts a line fill over
// a single-outstanding memory read port (mem_req/mem_addr/mem_ack, then
// mem_valid/mem_data). Entries are replaced round-robin via a victim pointer.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   init                 synchronous flush of all buffer state
//   fetch_order/pc       per-lane request and byte PC (bits [1:0] ignored)
//   fetch_done/instr     per-lane hit and instruction (combinational)
//   fetch_hint           link-register PC used by the optional prefetcher
//   mem_*                line read port, word 0 in the LSBs of mem_data
//
// Optional feature: define FETCH_PREFETCH_EN to let an idle unit preload the line
// holding fetch_hint.
module fetch_unit #(
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned ENTRIES     = 4,
  parameter int unsigned DECODE_PARA = 2,
  parameter int unsigned LEN_WORD    = 32,
  parameter int unsigned LEN_INST    = 32
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            init,
  input  logic [DECODE_PARA-1:0]          fetch_order,
  input  logic [LEN_WORD*DECODE_PARA-1:0] fetch_pc,
  output logic [DECODE_PARA-1:0]          fetch_done,
  output logic [LEN_INST*DECODE_PARA-1:0] fetch_instr,
  input  logic [LEN_WORD-1:0]             fetch_hint,
  output logic                            mem_req,
  output logic [LEN_WORD-1:0]             mem_addr,
  input  logic                            mem_ack,
  input  logic                            mem_valid,
  input  logic [LEN_INST*LINE_WORDS-1:0]  mem_data
);

  localparam int unsigned WordBits = $clog2(LINE_WORDS);
  localparam int unsigned OffBits  = WordBits + 2;
  localparam int unsigned TagW     = LEN_WORD - OffBits;
  localparam int unsigned IdxW     = $clog2(ENTRIES);
  localparam int unsigned LineW    = LEN_INST * LINE_WORDS;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

  function automatic logic [TagW-1:0] tag_of(input logic [LEN_WORD-1:0] pc);
    return pc[LEN_WORD-1:OffBits];
  endfunction

  state_e             state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TagW-1:0]    tag_q  [ENTRIES];
  logic [TagW-1:0]    tag_d  [ENTRIES];
  logic [LineW-1:0]   data_q [ENTRIES];
  logic [LineW-1:0]   data_d [ENTRIES];
  logic [IdxW-1:0]    victim_q, victim_d;
  logic [TagW-1:0]    miss_tag_q, miss_tag_d;
`ifdef FETCH_PREFETCH_EN
  logic [TagW-1:0]    last_pf_tag_q, last_pf_tag_d;
`endif

  // Low PC bits and (in the default build) the hint are not needed by the logic.
  logic unused_inputs;
  assign unused_inputs = ^{fetch_pc, fetch_hint};

  // Lane hit lookup; tags are never duplicated, so OR-ing matching lines is exact.
  logic [DECODE_PARA-1:0] hit;
  logic [LineW-1:0]       hit_line [DECODE_PARA];
  always_comb begin
    hit = '0;
    for (int d = 0; d < DECODE_PARA; d++) begin
      hit_line[d] = '0;
      for (int e = 0; e < ENTRIES; e++) begin
        if (valid_q[e] && tag_q[e] == tag_of(fetch_pc[d*LEN_WORD +: LEN_WORD])) begin
          hit[d]      = 1'b1;
          hit_line[d] = hit_line[d] | data_q[e];
        end
      end
    end
  end

  assign fetch_done = fetch_order & hit & {DECODE_PARA{~init}};

  always_comb begin
    fetch_instr = '0;
    for (int d = 0; d < DECODE_PARA; d++) begin
      if (fetch_done[d]) begin
        fetch_instr[d*LEN_INST +: LEN_INST] =
            hit_line[d][fetch_pc[d*LEN_WORD+2 +: WordBits]*LEN_INST +: LEN_INST];
      end
    end
  end

  // Lowest missing lane wins: scan downwards so lower lanes overwrite.
  logic            miss_found;
  logic [TagW-1:0] miss_tag;
  always_comb begin
    miss_found = 1'b0;
    miss_tag   = '0;
    for (int d = DECODE_PARA - 1; d >= 0; d--) begin
      if (fetch_order[d] && !hit[d]) begin
        miss_found = 1'b1;
        miss_tag   = tag_of(fetch_pc[d*LEN_WORD +: LEN_WORD]);
      end
    end
  end

  // Residency of the line being filled (dedupe) and of the hint line.
  logic            fill_hit, hint_hit;
  logic [IdxW-1:0] fill_idx;
  always_comb begin
    fill_hit = 1'b0;
    hint_hit = 1'b0;
    fill_idx = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      if (valid_q[e] && tag_q[e] == miss_tag_q) begin
        fill_hit = 1'b1;
        fill_idx = IdxW'(e);
      end
      if (valid_q[e] && tag_q[e] == tag_of(fetch_hint)) begin
        hint_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    victim_d   = victim_q;
    miss_tag_d = miss_tag_q;
`ifdef FETCH_PREFETCH_EN
    last_pf_tag_d = last_pf_tag_q;
`endif
    mem_req  = 1'b0;
    mem_addr = '0;

    unique case (state_q)
      StIdle: begin
        if (!init) begin
          if (miss_found) begin
            state_d    = StReq;
            miss_tag_d = miss_tag;
`ifdef FETCH_PREFETCH_EN
          end else if (!hint_hit && tag_of(fetch_hint) != last_pf_tag_q) begin
            state_d       = StReq;
            miss_tag_d    = tag_of(fetch_hint);
            last_pf_tag_d = tag_of(fetch_hint);
`endif
          end
        end
      end
      StReq: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_q, {OffBits{1'b0}}};
        if (init) begin
          // An ack in the flush cycle still owes us a data beat that must be swallowed.
          state_d = mem_ack ? StDrain : StIdle;
        end else if (mem_ack) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (init) begin
          state_d = mem_valid ? StIdle : StDrain;
        end else if (mem_valid) begin
          state_d = StIdle;
          if (fill_hit) begin
            data_d[fill_idx] = mem_data;
          end else begin
            valid_d[victim_q] = 1'b1;
            tag_d[victim_q]   = miss_tag_q;
            data_d[victim_q]  = mem_data;
            victim_d          = victim_q + IdxW'(1);
          end
        end
      end
      StDrain: begin
        if (mem_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (init) begin
      valid_d  = '0;
      victim_d = '0;
`ifdef FETCH_PREFETCH_EN
      last_pf_tag_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      victim_q   <= '0;
      miss_tag_q <= '0;
`ifdef FETCH_PREFETCH_EN
      last_pf_tag_q <= '0;
`endif
      for (int e = 0; e < ENTRIES; e++) begin
        tag_q[e]  <= '0;
        data_q[e] <= '0;
      end
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      victim_q   <= victim_d;
      miss_tag_q <= miss_tag_d;
`ifdef FETCH_PREFETCH_EN
      last_pf_tag_q <= last_pf_tag_d;
`endif
      for (int e = 0; e < ENTRIES; e++) begin
        tag_q[e]  <= tag_d[e];
        data_q[e] <= data_d[e];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hit table, miss fills, replacement, flush, same-cycle
// fill/order, async reset and (build dependent) hint prefetch.
module tb_fetch_unit;

  localparam int DP = 2;
  localparam int LW = 32;
  localparam int LI = 32;
  localparam int NW = 4;

`ifdef FETCH_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              init;
  logic [DP-1:0]     fetch_order;
  logic [LW*DP-1:0]  fetch_pc;
  logic [DP-1:0]     fetch_done;
  logic [LI*DP-1:0]  fetch_instr;
  logic [LW-1:0]     fetch_hint;
  logic              mem_req;
  logic [LW-1:0]     mem_addr;
  logic              mem_ack;
  logic              mem_valid;
  logic [LI*NW-1:0]  mem_data;

  fetch_unit #(
    .LINE_WORDS (NW),
    .ENTRIES    (4),
    .DECODE_PARA(DP),
    .LEN_WORD   (LW),
    .LEN_INST   (LI)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .init       (init),
    .fetch_order(fetch_order),
    .fetch_pc   (fetch_pc),
    .fetch_done (fetch_done),
    .fetch_instr(fetch_instr),
    .fetch_hint (fetch_hint),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  order;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [1:0]  done;
    logic [31:0] i0;
    logic [31:0] i1;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory image: line 0x100 holds 0xA0..0xA3, other lines encode address and word.
  function automatic logic [31:0] line_word(input logic [31:0] addr, input int i);
    if (addr == 32'h100) return 32'hA0 + 32'(i);
    return 32'hC000_0000 | (addr << 4) | 32'(i);
  endfunction

  function automatic logic [LI*NW-1:0] line_data(input logic [31:0] addr);
    logic [LI*NW-1:0] d;
    for (int i = 0; i < NW; i++) d[i*LI +: LI] = line_word(addr, i);
    return d;
  endfunction

  task automatic drive(input logic [1:0] order, input logic [31:0] pc0,
                       input logic [31:0] pc1);
    fetch_order = order;
    fetch_pc    = {pc1, pc0};
  endtask

  // Called at a negedge; waits a bounded number of cycles for a request.
  task automatic wait_req(input string name, input logic [31:0] exp_addr);
    int k = 0;
    while (!mem_req && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk({name, " req"}, {31'd0, mem_req}, 32'd1);
    chk({name, " addr"}, mem_addr, exp_addr);
  endtask

  // Ack the current request, then return data lat cycles after the ack.
  task automatic serve(input logic [31:0] addr, input int lat);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (lat - 1) @(negedge clk);
    mem_valid = 1'b1;
    mem_data  = line_data(addr);
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  task automatic fill(input logic [31:0] addr);
    drive(2'b01, addr, 32'h0);
    @(negedge clk);
    wait_req("fill", addr);
    serve(addr, 2);
    drive(2'b00, 32'h0, 32'h0);
  endtask

  // Combinational check; orders drop before the next posedge so misses start nothing.
  task automatic apply_vec(input int idx, input vec_t v);
    drive(v.order, v.pc0, v.pc1);
    #2;
    chk($sformatf("vec%0d done", idx), {30'd0, fetch_done}, {30'd0, v.done});
    chk($sformatf("vec%0d instr0", idx), fetch_instr[31:0], v.i0);
    chk($sformatf("vec%0d instr1", idx), fetch_instr[63:32], v.i1);
    drive(2'b00, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    int          nreq;
    logic [31:0] pf_addr;
    bit          wait_data;

    tbl[0] = '{2'b01, 32'h000, 32'h000, 2'b00, 32'h0,         32'h0};
    tbl[1] = '{2'b01, 32'h010, 32'h000, 2'b01, 32'hC000_0100, 32'h0};
    tbl[2] = '{2'b11, 32'h014, 32'h028, 2'b11, 32'hC000_0101, 32'hC000_0202};
    tbl[3] = '{2'b10, 32'h000, 32'h03F, 2'b10, 32'h0,         32'hC000_0303};
    tbl[4] = '{2'b11, 32'h044, 32'h000, 2'b01, 32'hC000_0401, 32'h0};
    tbl[5] = '{2'b00, 32'h010, 32'h010, 2'b00, 32'h0,         32'h0};
    tbl[6] = '{2'b10, 32'h000, 32'h100, 2'b00, 32'h0,         32'h0};
    tbl[7] = '{2'b01, 32'h04C, 32'h000, 2'b01, 32'hC000_0403, 32'h0};

    rstn = 1'b0; init = 1'b0; fetch_hint = '0; mem_ack = 1'b0; mem_valid = 1'b0;
    mem_data = '0;
    drive(2'b11, 32'h100, 32'h200);
    #2;
    chk("reset done", {30'd0, fetch_done}, 32'd0);
    chk("reset instr", fetch_instr[31:0] | fetch_instr[63:32], 32'd0);
    chk("reset req", {31'd0, mem_req}, 32'd0);
    chk("reset addr", mem_addr, 32'd0);
    drive(2'b00, 32'h0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Basic miss then hit, 1-cycle data return.
    drive(2'b01, 32'h100, 32'h0);
    #2;
    chk("miss done", {30'd0, fetch_done}, 32'd0);
    @(negedge clk);
    chk("miss req", {31'd0, mem_req}, 32'd1);
    chk("miss addr", mem_addr, 32'h100);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("wait req low", {31'd0, mem_req}, 32'd0);
    mem_valid = 1'b1;
    mem_data  = line_data(32'h100);
    #2;
    chk("no bypass", {30'd0, fetch_done}, 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    chk("fill hit done", {30'd0, fetch_done}, 32'd1);
    chk("fill hit instr", fetch_instr[31:0], 32'hA0);
    drive(2'b01, 32'h10C, 32'h0);
    #2;
    chk("word3 instr", fetch_instr[31:0], 32'hA3);
    chk("no extra req", {31'd0, mem_req}, 32'd0);
    drive(2'b00, 32'h0, 32'h0);
    @(negedge clk);

    // Flush, then overfill so 0x040 replaces 0x000.
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    fill(32'h000);
    fill(32'h010);
    fill(32'h020);
    fill(32'h030);
    fill(32'h040);
    for (int i = 0; i < 8; i++) apply_vec(i, tbl[i]);

    // Lane0 hit alongside lane1 miss.
    fill(32'h100);
    drive(2'b11, 32'h100, 32'h200);
    #2;
    chk("mixed done", {30'd0, fetch_done}, 32'd1);
    chk("mixed instr0", fetch_instr[31:0], 32'hA0);
    chk("mixed instr1", fetch_instr[63:32], 32'h0);
    @(negedge clk);
    wait_req("lane1 miss", 32'h200);
    serve(32'h200, 1);
    #2;
    chk("lane1 filled", {30'd0, fetch_done}, 32'd3);
    chk("lane1 instr", fetch_instr[63:32], 32'hC000_2000);
    drive(2'b00, 32'h0, 32'h0);
    @(negedge clk);

    // Two misses: lowest lane goes first.
    drive(2'b11, 32'h500, 32'h600);
    @(negedge clk);
    wait_req("priority", 32'h500);
    drive(2'b00, 32'h0, 32'h0);
    serve(32'h500, 1);

    // init during WAIT: data is drained, buffer flushed.
    drive(2'b01, 32'h700, 32'h0);
    @(negedge clk);
    wait_req("pre-init", 32'h700);
    drive(2'b00, 32'h0, 32'h0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    init = 1'b1;
    drive(2'b10, 32'h0, 32'h200);
    #2;
    chk("init masks done", {30'd0, fetch_done}, 32'd0);
    @(negedge clk);
    init = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    chk("drain req low", {31'd0, mem_req}, 32'd0);
    mem_valid = 1'b1;
    mem_data  = line_data(32'h700);
    @(negedge clk);
    mem_valid = 1'b0;
    chk("victim reset", 32'(dut.victim_q), 32'd0);
    chk("post drain req", {31'd0, mem_req}, 32'd0);
    drive(2'b10, 32'h0, 32'h200);
    #2;
    chk("flushed line", {30'd0, fetch_done}, 32'd0);
    drive(2'b01, 32'h700, 32'h0);
    #2;
    chk("drained miss", {30'd0, fetch_done}, 32'd0);
    @(negedge clk);
    wait_req("refetch", 32'h700);
    serve(32'h700, 1);
    #2;
    chk("refetch hit", fetch_instr[31:0], 32'hC000_7000);
    drive(2'b00, 32'h0, 32'h0);
    @(negedge clk);

    // Same-cycle fill and order; lane1 miss in that cycle waits for IDLE.
    drive(2'b01, 32'h100, 32'h0);
    @(negedge clk);
    wait_req("same-cycle", 32'h100);
    drive(2'b00, 32'h0, 32'h0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_data  = line_data(32'h100);
    drive(2'b11, 32'h100, 32'h800);
    #2;
    chk("same-cycle done", {30'd0, fetch_done}, 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    #2;
    chk("next-cycle done", {30'd0, fetch_done}, 32'd1);
    chk("next-cycle instr", fetch_instr[31:0], 32'hA0);
    chk("idle after fill", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    chk("new req", {31'd0, mem_req}, 32'd1);
    chk("new req addr", mem_addr, 32'h800);
    serve(32'h800, 1);
    drive(2'b00, 32'h0, 32'h0);
    @(negedge clk);

    // Asynchronous reset mid-request.
    drive(2'b01, 32'h900, 32'h0);
    @(negedge clk);
    chk("pre-reset req", {31'd0, mem_req}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async req", {31'd0, mem_req}, 32'd0);
    chk("async addr", mem_addr, 32'd0);
    drive(2'b00, 32'h0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    drive(2'b01, 32'h100, 32'h0);
    #2;
    chk("reset flushed", {30'd0, fetch_done}, 32'd0);
    drive(2'b00, 32'h0, 32'h0);
    @(negedge clk);

    // Hint prefetch with idle lanes.
    fetch_hint = 32'h300;
    nreq = 0;
    pf_addr = '0;
    wait_data = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mem_ack   = 1'b0;
      mem_valid = 1'b0;
      if (wait_data) begin
        mem_valid = 1'b1;
        mem_data  = line_data(pf_addr);
        wait_data = 1'b0;
      end else if (mem_req) begin
        nreq++;
        pf_addr   = mem_addr;
        mem_ack   = 1'b1;
        wait_data = 1'b1;
      end
      @(negedge clk);
    end
    mem_ack   = 1'b0;
    mem_valid = 1'b0;
    chk("prefetch count", 32'(nreq), PF ? 32'd1 : 32'd0);
    chk("prefetch addr", pf_addr, PF ? 32'h300 : 32'h0);
    drive(2'b01, 32'h304, 32'h0);
    #2;
    chk("prefetch hit", {30'd0, fetch_done}, PF ? 32'd1 : 32'd0);
    chk("prefetch instr", fetch_instr[31:0], PF ? 32'hC000_3001 : 32'h0);
    drive(2'b00, 32'h0, 32'h0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
